// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic tap sequencer and its coordinate clamp.
// The optional stats counters in the top are enabled by defining BICUBIC_SEQ_STATS_EN.
package bicubic_pkg;
  localparam int SHIFT_AMOUNT = 8;
  localparam int DIM_W = 16;
  localparam int TAPS_PER_PIX = 16;
  localparam logic signed [2:0] OFF_MIN = -3'sd1;
  localparam logic signed [2:0] OFF_MAX = 3'sd2;
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, FIN} seq_state_e;

  typedef struct packed {
    logic [DIM_W-1:0]   i;
    logic [DIM_W-1:0]   j;
    logic signed [2:0]  m;
    logic signed [2:0]  n;
    logic signed [31:0] x_old;
    logic signed [31:0] y_old;
    logic signed [31:0] dx;
    logic signed [31:0] dy;
    logic [DIM_W-1:0]   src_x;
    logic [DIM_W-1:0]   src_y;
    logic               pix_last;
    logic               frm_last;
  } tap_desc_t;

  // Distance from the sample point to tap offset `off`, in Q.8, using only the fraction.
  function automatic logic signed [31:0] frac_delta(input logic [SHIFT_AMOUNT-1:0] frac,
                                                    input logic signed [2:0] off);
    return $signed({{(32-SHIFT_AMOUNT){1'b0}}, frac}) - ($signed(32'(off)) <<< SHIFT_AMOUNT);
  endfunction
endpackage

// File: rtl/bicubic_coord_clamp.sv
// Combinational edge clamp: old+off limited to 0..limit-1.
module bicubic_coord_clamp
  import bicubic_pkg::*;
(
  input  logic signed [31:0] i_old,
  input  logic signed [2:0]  i_off,
  input  logic [DIM_W-1:0]   i_limit,
  output logic [DIM_W-1:0]   o_coord
);
  logic signed [31:0] w_sum;

  assign w_sum = i_old + 32'(i_off);

  always_comb begin
    if (w_sum < 0)
      o_coord = '0;
    else if (w_sum >= $signed({{(32-DIM_W){1'b0}}, i_limit}))
      o_coord = i_limit - DIM_ONE;
    else
      o_coord = w_sum[DIM_W-1:0];
  end
endmodule

// File: rtl/bicubic_tap_sequencer.sv
// Walks every destination pixel and its 16 bicubic taps, issuing one registered descriptor per handshake.
// Define BICUBIC_SEQ_STATS_EN to add the stall_cnt / tap_cnt statistics ports.
module bicubic_tap_sequencer
  import bicubic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DIM_W-1:0]   src_rows,
  input  logic [DIM_W-1:0]   src_cols,
  input  logic [DIM_W-1:0]   dst_rows,
  input  logic [DIM_W-1:0]   dst_cols,
  input  logic [31:0]        x_ratio,
  input  logic [31:0]        y_ratio,
  output logic               busy,
  output logic               done,
  output logic               tap_valid,
  input  logic               tap_ready,
  output logic [DIM_W-1:0]   tap_i,
  output logic [DIM_W-1:0]   tap_j,
  output logic [2:0]         tap_m,
  output logic [2:0]         tap_n,
  output logic [31:0]        tap_x_old,
  output logic [31:0]        tap_y_old,
  output logic [31:0]        tap_dx,
  output logic [31:0]        tap_dy,
  output logic [DIM_W-1:0]   tap_src_x,
  output logic [DIM_W-1:0]   tap_src_y,
  output logic               tap_pix_last,
  output logic               tap_frm_last
`ifdef BICUBIC_SEQ_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        tap_cnt
`endif
);
  seq_state_e         r_state;
  logic               r_busy, r_done, r_valid;
  tap_desc_t          r_desc;
  logic signed [31:0] r_x_acc, r_y_acc, r_x_ratio, r_y_ratio;
  logic [DIM_W-1:0]   r_src_rows, r_src_cols, r_dst_rows, r_dst_cols;

  logic               w_idle, w_accept;
  logic [DIM_W-1:0]   w_cfg_src_rows, w_cfg_src_cols, w_cfg_dst_rows, w_cfg_dst_cols;
  logic [DIM_W-1:0]   w_nx_i, w_nx_j, w_src_x, w_src_y;
  logic signed [2:0]  w_nx_m, w_nx_n;
  logic signed [31:0] w_nx_x_acc, w_nx_y_acc, w_x_old, w_y_old;
  tap_desc_t          w_nxt_desc;

  // Handshake: a tap transfers on a rising edge where tap_valid && tap_ready; the
  // descriptor never changes while tap_valid is high and tap_ready is low.
  assign w_idle   = (r_state == IDLE);
  assign w_accept = r_valid && tap_ready;

  // In IDLE the descriptor for the first tap is built straight from the start-time config.
  assign w_cfg_src_rows = w_idle ? src_rows : r_src_rows;
  assign w_cfg_src_cols = w_idle ? src_cols : r_src_cols;
  assign w_cfg_dst_rows = w_idle ? dst_rows : r_dst_rows;
  assign w_cfg_dst_cols = w_idle ? dst_cols : r_dst_cols;

  always_comb begin
    w_nx_i     = r_desc.i;
    w_nx_j     = r_desc.j;
    w_nx_m     = r_desc.m;
    w_nx_n     = r_desc.n;
    w_nx_x_acc = r_x_acc;
    w_nx_y_acc = r_y_acc;
    if (w_idle) begin
      w_nx_i     = '0;
      w_nx_j     = '0;
      w_nx_m     = OFF_MIN;
      w_nx_n     = OFF_MIN;
      w_nx_x_acc = '0;
      w_nx_y_acc = '0;
    end else if (r_desc.n != OFF_MAX) begin
      w_nx_n = r_desc.n + 3'sd1;
    end else begin
      w_nx_n = OFF_MIN;
      if (r_desc.m != OFF_MAX) begin
        w_nx_m = r_desc.m + 3'sd1;
      end else begin
        w_nx_m = OFF_MIN;
        if (r_desc.j != r_dst_cols - DIM_ONE) begin
          w_nx_j     = r_desc.j + DIM_ONE;
          w_nx_x_acc = r_x_acc + r_x_ratio;
        end else begin
          w_nx_j     = '0;
          w_nx_x_acc = '0;
          w_nx_i     = r_desc.i + DIM_ONE;
          w_nx_y_acc = r_y_acc + r_y_ratio;
        end
      end
    end
  end

  assign w_x_old = w_nx_x_acc >>> SHIFT_AMOUNT;
  assign w_y_old = w_nx_y_acc >>> SHIFT_AMOUNT;

  bicubic_coord_clamp u_clamp_x (
    .i_old(w_x_old), .i_off(w_nx_n), .i_limit(w_cfg_src_cols), .o_coord(w_src_x)
  );
  bicubic_coord_clamp u_clamp_y (
    .i_old(w_y_old), .i_off(w_nx_m), .i_limit(w_cfg_src_rows), .o_coord(w_src_y)
  );

  always_comb begin
    w_nxt_desc.i        = w_nx_i;
    w_nxt_desc.j        = w_nx_j;
    w_nxt_desc.m        = w_nx_m;
    w_nxt_desc.n        = w_nx_n;
    w_nxt_desc.x_old    = w_x_old;
    w_nxt_desc.y_old    = w_y_old;
    w_nxt_desc.dx       = frac_delta(w_nx_x_acc[SHIFT_AMOUNT-1:0], w_nx_n);
    w_nxt_desc.dy       = frac_delta(w_nx_y_acc[SHIFT_AMOUNT-1:0], w_nx_m);
    w_nxt_desc.src_x    = w_src_x;
    w_nxt_desc.src_y    = w_src_y;
    w_nxt_desc.pix_last = (w_nx_m == OFF_MAX) && (w_nx_n == OFF_MAX);
    w_nxt_desc.frm_last = w_nxt_desc.pix_last && (w_nx_j == w_cfg_dst_cols - DIM_ONE)
                          && (w_nx_i == w_cfg_dst_rows - DIM_ONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_desc     <= '0;
      r_x_acc    <= '0;
      r_y_acc    <= '0;
      r_x_ratio  <= '0;
      r_y_ratio  <= '0;
      r_src_rows <= '0;
      r_src_cols <= '0;
      r_dst_rows <= '0;
      r_dst_cols <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_src_rows <= src_rows;
            r_src_cols <= src_cols;
            r_dst_rows <= dst_rows;
            r_dst_cols <= dst_cols;
            r_x_ratio  <= x_ratio;
            r_y_ratio  <= y_ratio;
            r_x_acc    <= w_nx_x_acc;
            r_y_acc    <= w_nx_y_acc;
            r_busy     <= 1'b1;
            if (dst_rows == '0 || dst_cols == '0) begin
              r_state <= FIN;
            end else begin
              r_state <= ISSUE;
              r_valid <= 1'b1;
              r_desc  <= w_nxt_desc;
            end
          end
        end
        ISSUE: begin
          if (w_accept) begin
            if (r_desc.frm_last) begin
              r_state <= FIN;
              r_valid <= 1'b0;
            end else begin
              r_desc  <= w_nxt_desc;
              r_x_acc <= w_nx_x_acc;
              r_y_acc <= w_nx_y_acc;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign tap_valid    = r_valid;
  assign tap_i        = r_desc.i;
  assign tap_j        = r_desc.j;
  assign tap_m        = r_desc.m;
  assign tap_n        = r_desc.n;
  assign tap_x_old    = r_desc.x_old;
  assign tap_y_old    = r_desc.y_old;
  assign tap_dx       = r_desc.dx;
  assign tap_dy       = r_desc.dy;
  assign tap_src_x    = r_desc.src_x;
  assign tap_src_y    = r_desc.src_y;
  assign tap_pix_last = r_desc.pix_last;
  assign tap_frm_last = r_desc.frm_last;

`ifdef BICUBIC_SEQ_STATS_EN
  logic [31:0] r_stall_cnt, r_tap_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_tap_cnt   <= '0;
    end else if (!abort && w_idle && start) begin
      r_stall_cnt <= '0;
      r_tap_cnt   <= '0;
    end else if (!abort) begin
      if (r_valid && !tap_ready && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_accept && r_tap_cnt != '1)
        r_tap_cnt <= r_tap_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign tap_cnt   = r_tap_cnt;
`endif
endmodule
